// File: rtl/video_timing_if.sv
// video_timing_if
//   Bundle between the raster timing generator (master) and its consumer
//   (slave: frame-buffer reader plus TMDS encoders).
//
//   Handshake semantics: there is no ready path. pix_req is a strobe and
//   req_x/req_y are valid only in a cycle where it is high. The consumer
//   must accept every request and return the pixel exactly REQ_LEAD cycles
//   later, when de rises with the same coordinates on pix_x/pix_y.
//   enable is a level request from the consumer side.
//
//   Signals
//     enable       slave -> master  run request, honoured at frame boundaries
//     running      master -> slave  generator is not idle
//     pix_req      master -> slave  pixel request strobe
//     req_x/req_y  master -> slave  coordinates of the requested pixel
//     de           master -> slave  data enable, aligned with pix_x/pix_y
//     hsync/vsync  master -> slave  sync outputs, polarity set by generator
//     pix_x/pix_y  master -> slave  coordinates of the current output pixel
//     frame_start  master -> slave  pulse with de at (0,0)
//     line_start   master -> slave  pulse with de at x=0 of each active line
interface video_timing_if #(
  parameter int CNT_W = 10
) ();
  logic             enable;
  logic             running;
  logic             pix_req;
  logic [CNT_W-1:0] req_x;
  logic [CNT_W-1:0] req_y;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;
  logic             line_start;

  modport master (
    input  enable,
    output running, pix_req, req_x, req_y, de, hsync, vsync,
           pix_x, pix_y, frame_start, line_start
  );

  modport slave (
    output enable,
    input  running, pix_req, req_x, req_y, de, hsync, vsync,
           pix_x, pix_y, frame_start, line_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Progressive raster timing generator. Produces a pixel request stage
//   (pix_req, req_x/req_y) and, REQ_LEAD cycles later, the output stage
//   (de, pix_x/pix_y, hsync, vsync, frame_start, line_start). Start and
//   stop only take effect on frame boundaries.
//
//   Ports
//     pixel_clk       pixel clock, sole clock
//     screen_reset_n  asynchronous active-low reset
//     vid             video_timing_if master side (see interface header)
//     dbg_state       current FSM state (IDLE=0, RUN=1, DRAIN=2)
module video_timing_gen #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit HS_ACTIVE_HIGH = 1'b1,
  parameter bit VS_ACTIVE_HIGH = 1'b1,
  parameter int REQ_LEAD       = 2,
  parameter int CNT_W          = 10
) (
  input  logic                 pixel_clk,
  input  logic                 screen_reset_n,
  video_timing_if.master       vid,
  output logic [1:0]           dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic             req;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hs;
    logic             vs;
    logic             fs;
    logic             ls;
  } stage_t;

  localparam stage_t BLANK = '{req: 1'b0, x: '0, y: '0,
                               hs: ~HS_ACTIVE_HIGH, vs: ~VS_ACTIVE_HIGH,
                               fs: 1'b0, ls: 1'b0};

  logic [1:0]       state_q, state_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             counting;
  logic             at_last;
  logic             active;
  stage_t           s1;
  // Index 0 is the request stage; index REQ_LEAD is the output stage.
  stage_t           pipe_q [REQ_LEAD+1];
  stage_t           pipe_d [REQ_LEAD+1];

  assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign at_last  = (h_q == H_LAST_C) && (v_q == V_LAST_C);
  assign active   = (h_q < H_ACT_C) && (v_q < V_ACT_C);

  // enable is registered once; every FSM decision uses the registered copy.
  assign en_d = vid.enable;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: if (en_q) state_d = ST_RUN;
      // DRAIN differs from RUN only in that it ends the run at the wrap.
      ST_RUN, ST_DRAIN: begin
        if (at_last) state_d = en_q ? ST_RUN : ST_IDLE;
        else         state_d = en_q ? ST_RUN : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (counting) begin
      if (h_q == H_LAST_C) begin
        h_d = '0;
        v_d = (v_q == V_LAST_C) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end else begin
      h_d = '0;
      v_d = '0;
    end
  end

  always_comb begin
    s1 = BLANK;
    if (counting) begin
      s1.req = active;
      s1.x   = h_q;
      s1.y   = v_q;
      s1.hs  = ((h_q >= HS_BEG_C) && (h_q < HS_END_C)) ? HS_ACTIVE_HIGH : ~HS_ACTIVE_HIGH;
      s1.vs  = ((v_q >= VS_BEG_C) && (v_q < VS_END_C)) ? VS_ACTIVE_HIGH : ~VS_ACTIVE_HIGH;
      s1.fs  = active && (h_q == '0) && (v_q == '0);
      s1.ls  = active && (h_q == '0);
    end
    pipe_d[0] = s1;
    for (int i = 1; i <= REQ_LEAD; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge pixel_clk or negedge screen_reset_n) begin
    if (!screen_reset_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      for (int i = 0; i <= REQ_LEAD; i++) pipe_q[i] <= BLANK;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pipe_q  <= pipe_d;
    end
  end

  assign vid.running     = counting;
  assign vid.pix_req     = pipe_q[0].req;
  assign vid.req_x       = pipe_q[0].x;
  assign vid.req_y       = pipe_q[0].y;
  assign vid.de          = pipe_q[REQ_LEAD].req;
  assign vid.pix_x       = pipe_q[REQ_LEAD].x;
  assign vid.pix_y       = pipe_q[REQ_LEAD].y;
  assign vid.hsync       = pipe_q[REQ_LEAD].hs;
  assign vid.vsync       = pipe_q[REQ_LEAD].vs;
  assign vid.frame_start = pipe_q[REQ_LEAD].fs;
  assign vid.line_start  = pipe_q[REQ_LEAD].ls;
  assign dbg_state       = state_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI/DVI output path. It produces hsync, vsync and data-enable for any progressive mode from a single pixel clock. A pixel-request strobe with coordinates is issued a configurable number of cycles ahead of data-enable, which absorbs frame-buffer read latency. Start and stop take effect only on frame boundaries, so the downstream TMDS encoders never see a partial frame.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_ACTIVE_HIGH, 1, hsync polarity; 1 = high while in sync
- VS_ACTIVE_HIGH, 1, vsync polarity; 1 = high while in sync
- REQ_LEAD, 2, cycles from pix_req to the matching de; legal range 0..8
- CNT_W, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

- pixel_clk  in  1  pixel clock; sole clock
- screen_reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; honoured only at frame boundaries
- running  out  1  high while state is not IDLE
- pix_req  out  1  pixel request; req_x/req_y valid while high
- req_x, req_y  out  CNT_W  coordinates of the requested pixel
- de  out  1  data enable, aligned with pix_x/pix_y
- hsync, vsync  out  1  sync outputs, polarity per parameter
- pix_x, pix_y  out  CNT_W  coordinates of the current output pixel
- frame_start  out  1  one-cycle pulse with de at (0,0)
- line_start  out  1  one-cycle pulse with de at x=0 of every active line

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Counter order along a line: active, FP, SYNC, BP. Counter order down a frame: active, FP, SYNC, BP.
- Horizontal sync region: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vertical sync region is the same form on v, and vsync is decided by v alone.
- h counts 0..H_TOTAL-1 and wraps. v increments on each h wrap and itself wraps after V_TOTAL-1.
- FSM states and transitions:
  - IDLE: counters held at (0,0). Goes to RUN when enable=1.
  - RUN: counting. Goes to DRAIN when enable=0.
  - DRAIN: counting. Goes to RUN when enable=1, with no visible effect on the raster. At the last position (H_TOTAL-1, V_TOTAL-1) it goes to IDLE if enable=0, otherwise it stays counting (RUN).
- Stage 1 is a register of counter-derived values: pix_req = active && state≠IDLE, plus req_x/req_y and the raw syncs.
- Output stage: stage 1 delayed by a further REQ_LEAD registers, driving de, pix_x, pix_y, hsync, vsync, frame_start and line_start.
- In IDLE, stage 1 is loaded with blank values: pix_req=0, syncs inactive.
- The pipeline keeps shifting in IDLE, so the last REQ_LEAD blank entries flush out normally.
- pix_x/pix_y equal req_x/req_y delayed by exactly REQ_LEAD cycles.
- Coordinates outside the active region still report the counter value. Consumers qualify them with de or pix_req.

## Timing
- Reset (asynchronous, immediate): state IDLE, counters 0, all pipeline registers blank.
  - Outputs: running=0, pix_req=0, de=0, frame_start=0, line_start=0, all coordinates 0.
  - hsync = ~HS_ACTIVE_HIGH, vsync = ~VS_ACTIVE_HIGH.
- Reset asserted mid-frame truncates the frame. After release the block restarts from IDLE.
- Start sequence, with enable sampled high in IDLE at edge N:
  - edge N+1: RUN, counter (0,0), running=1.
  - edge N+2: pix_req=1 with req (0,0).
  - edge N+2+REQ_LEAD: de=1, frame_start=1, line_start=1, pix (0,0).
- Sync-to-de relation is fixed at the output stage: hsync asserts H_ACTIVE+H_FP cycles after de rises on the same line.
- Stop: the last output pixel of the frame is followed by REQ_LEAD+1 blank cycles, then the outputs hold blank. running falls on the edge after counter (H_TOTAL-1, V_TOTAL-1).
- enable toggling in the same cycle as the wrap: the value sampled at the wrap edge decides.

## Test plan
- Reset: hold screen_reset_n=0 with enable=1 → all outputs at their reset values. Assert reset mid-line → outputs blank in the same cycle with no clock edge.
- Start latency at defaults: enable rises → pix_req at 2 edges, de plus frame_start at 4 edges. req_x sequence 0..639 leads pix_x by exactly 2 cycles.
- Line/frame timing at defaults:
  - de is high for 640 cycles per 800-cycle line.
  - hsync is high for 96 cycles, starting 656 cycles after de rises.
  - vsync is high for all of lines 490–491.
  - frame_start period is 420000 cycles.
- Graceful stop: drop enable at line 100 → frame completes all 480 active lines, running falls after (799,524), no further de. Re-raise enable during DRAIN → the next frame starts seamlessly with period still 420000.
- Small mode: H 4/1/2/1, V 3/1/1/1, REQ_LEAD=0, both polarities 0:
  - line period 8, de high for 4 cycles.
  - hsync low during positions 5–6; vsync low during line 4.
  - frame period 48.
- Boundary: enable toggles exactly on the wrap cycle → decision follows the sampled value. Confirm no glitch on de or frame_start.
